// File: rtl/uart_pkg.sv
// Shared UART receiver types and frame constants.
// No logic; imported by uart_rx and its bench.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic 2-flop synchroniser with a configurable reset value.
// Latency 2 cycles; no backpressure.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; out_ready pulses 2+CPB/2+9*CPB edges after the start edge.
// No backpressure: each byte is presented for one cycle and held on out_frame until the next.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_rx,
  output logic [DATA_BITS-1:0] out_frame,
  output logic                 out_ready,
  output logic                 out_frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DATA_BITS-1:0] frame_nxt;
  logic                 ready_nxt, ferr_nxt;

  // Idle-high line: reset value 1 keeps a reset from looking like a start bit.
  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .d      (in_rx),
    .q      (rx_s)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      out_frame       <= '0;
      out_ready       <= 1'b0;
      out_frame_error <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bit_idx         <= bit_idx_nxt;
      shift_reg       <= shift_nxt;
      out_frame       <= frame_nxt;
      out_ready       <= ready_nxt;
      out_frame_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    frame_nxt   = out_frame;
    ready_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          // A start bit that is no longer low at its midpoint was a glitch.
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            frame_nxt = shift_reg;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = RECOVER;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RECOVER: begin
        // Hold off until the line returns high so a break yields one error only.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at the default bit period, one fast instance for the scenarios.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int NF = 24;
  localparam int ND = CLKS_PER_BIT_DEFAULT;
  localparam int LF = 2 + NF / 2 + 9 * NF;
  localparam int LD = 2 + ND / 2 + 9 * ND;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       rx_f = 1'b1;
  logic       rx_d = 1'b1;
  logic [7:0] f_frame, d_frame;
  logic       f_ready, f_err, d_ready, d_err;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int both_cnt = 0;
  int d_err_cnt = 0;

  logic [7:0] f_dat_q[$];
  int         f_stamp_q[$];
  int         f_err_q[$];
  logic [7:0] d_dat_q[$];
  int         d_stamp_q[$];

  uart_rx #(.CLKS_PER_BIT(NF)) u_fast (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_rx           (rx_f),
    .out_frame       (f_frame),
    .out_ready       (f_ready),
    .out_frame_error (f_err)
  );

  uart_rx u_dflt (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_rx           (rx_d),
    .out_frame       (d_frame),
    .out_ready       (d_ready),
    .out_frame_error (d_err)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) edge_cnt <= edge_cnt + 1;

  // Stamp each pulse with the edge that raised it.
  always @(negedge in_clk) begin
    if (f_ready) begin
      f_dat_q.push_back(f_frame);
      f_stamp_q.push_back(edge_cnt);
    end
    if (f_err) f_err_q.push_back(edge_cnt);
    if (f_ready && f_err) both_cnt++;
    if (d_ready && d_err) both_cnt++;
    if (d_ready) begin
      d_dat_q.push_back(d_frame);
      d_stamp_q.push_back(edge_cnt);
    end
    if (d_err) d_err_cnt++;
  end

  task automatic hold(input bit dflt, input logic v, input int n);
    if (dflt) rx_d = v;
    else      rx_f = v;
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  // Serialise one 8N1 frame; e0 is the edge at which the synchroniser first sees the start bit.
  task automatic send(input bit dflt, input logic [7:0] b, input logic stop, output int e0);
    int n;
    n  = dflt ? ND : NF;
    e0 = edge_cnt + 1;
    hold(dflt, 1'b0, n);
    for (int i = 0; i < 8; i++) hold(dflt, b[i], n);
    hold(dflt, stop, n);
  endtask

  task automatic clear_f();
    f_dat_q.delete();
    f_stamp_q.delete();
    f_err_q.delete();
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    checks++;
    if (f_frame !== 8'h00 || d_frame !== 8'h00) begin
      errors++;
      $display("FAIL reset_frame: got %h/%h want 00/00", f_frame, d_frame);
    end
    checks++;
    if (f_ready !== 1'b0 || d_ready !== 1'b0 || f_err !== 1'b0 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got rdy %b/%b err %b/%b want all 0", f_ready, d_ready, f_err, d_err);
    end
    in_rst = 1'b0;
    hold(1'b0, 1'b1, 4);
  endtask

  task automatic test_default_latency();
    int e0;
    send(1'b1, 8'hA5, 1'b1, e0);
    hold(1'b1, 1'b1, 20);
    checks++;
    if (d_dat_q.size() != 1) begin
      errors++;
      $display("FAIL dflt_count: got %0d ready pulses want 1", d_dat_q.size());
    end
    if (d_dat_q.size() >= 1) begin
      checks++;
      if (d_dat_q[0] !== 8'hA5) begin
        errors++;
        $display("FAIL dflt_data: got %h want a5", d_dat_q[0]);
      end
      checks++;
      if (d_stamp_q[0] != e0 + LD) begin
        errors++;
        $display("FAIL dflt_latency: got edge %0d want %0d", d_stamp_q[0], e0 + LD);
      end
    end
    checks++;
    if (d_err_cnt != 0 || d_frame !== 8'hA5) begin
      errors++;
      $display("FAIL dflt_final: got err %0d frame %h want 0 a5", d_err_cnt, d_frame);
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    clear_f();
    send(1'b0, 8'h12, 1'b1, e1);
    send(1'b0, 8'h34, 1'b1, e2);
    hold(1'b0, 1'b1, 2 * NF);
    checks++;
    if (f_dat_q.size() != 2 || f_err_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got rdy %0d err %0d want 2 0", f_dat_q.size(), f_err_q.size());
    end
    if (f_dat_q.size() == 2) begin
      checks++;
      if (f_dat_q[0] !== 8'h12 || f_dat_q[1] !== 8'h34) begin
        errors++;
        $display("FAIL b2b_data: got %h %h want 12 34", f_dat_q[0], f_dat_q[1]);
      end
      checks++;
      if (f_stamp_q[0] != e1 + LF || f_stamp_q[1] - f_stamp_q[0] != 10 * NF) begin
        errors++;
        $display("FAIL b2b_timing: got %0d gap %0d want %0d gap %0d",
                 f_stamp_q[0], f_stamp_q[1] - f_stamp_q[0], e1 + LF, 10 * NF);
      end
    end
  endtask

  task automatic test_glitch();
    int e0;
    clear_f();
    hold(1'b0, 1'b0, NF / 4);
    hold(1'b0, 1'b1, 3 * NF);
    checks++;
    if (f_dat_q.size() != 0 || f_err_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_pulses: got rdy %0d err %0d want 0 0", f_dat_q.size(), f_err_q.size());
    end
    checks++;
    if (u_fast.state !== IDLE) begin
      errors++;
      $display("FAIL glitch_state: got %0d want IDLE", u_fast.state);
    end
    send(1'b0, 8'hC3, 1'b1, e0);
    hold(1'b0, 1'b1, NF);
    checks++;
    if (f_dat_q.size() != 1 || f_frame !== 8'hC3) begin
      errors++;
      $display("FAIL glitch_after: got rdy %0d frame %h want 1 c3", f_dat_q.size(), f_frame);
    end
  endtask

  task automatic test_frame_error();
    int ea, eb;
    clear_f();
    send(1'b0, 8'h3C, 1'b1, ea);
    send(1'b0, 8'h55, 1'b0, eb);
    hold(1'b0, 1'b1, 2 * NF);
    checks++;
    if (f_dat_q.size() != 1 || f_err_q.size() != 1) begin
      errors++;
      $display("FAIL ferr_count: got rdy %0d err %0d want 1 1", f_dat_q.size(), f_err_q.size());
    end
    if (f_err_q.size() == 1) begin
      checks++;
      if (f_err_q[0] != eb + LF) begin
        errors++;
        $display("FAIL ferr_latency: got edge %0d want %0d", f_err_q[0], eb + LF);
      end
    end
    checks++;
    if (f_frame !== 8'h3C) begin
      errors++;
      $display("FAIL ferr_frame: got %h want 3c", f_frame);
    end
  endtask

  task automatic test_break();
    int eb, e0;
    clear_f();
    eb = edge_cnt + 1;
    hold(1'b0, 1'b0, 20 * NF);
    hold(1'b0, 1'b1, 2 * NF);
    send(1'b0, 8'h81, 1'b1, e0);
    hold(1'b0, 1'b1, 2 * NF);
    checks++;
    if (f_err_q.size() != 1) begin
      errors++;
      $display("FAIL break_err_count: got %0d want 1", f_err_q.size());
    end
    if (f_err_q.size() == 1) begin
      checks++;
      if (f_err_q[0] != eb + LF) begin
        errors++;
        $display("FAIL break_err_edge: got %0d want %0d", f_err_q[0], eb + LF);
      end
    end
    checks++;
    if (f_dat_q.size() != 1 || f_frame !== 8'h81) begin
      errors++;
      $display("FAIL break_rx: got rdy %0d frame %h want 1 81", f_dat_q.size(), f_frame);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int e0;
    b = 8'h6B;
    clear_f();
    hold(1'b0, 1'b0, NF);
    for (int i = 0; i < 4; i++) hold(1'b0, b[i], NF);
    hold(1'b0, b[4], NF / 2);
    in_rst = 1'b1;
    hold(1'b0, b[4], NF / 2);
    checks++;
    if (f_frame !== 8'h00 || f_ready !== 1'b0 || f_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h %b %b want 00 0 0", f_frame, f_ready, f_err);
    end
    for (int i = 5; i < 8; i++) hold(1'b0, b[i], NF);
    hold(1'b0, 1'b1, NF);
    in_rst = 1'b0;
    hold(1'b0, 1'b1, 2 * NF);
    checks++;
    if (f_dat_q.size() != 0 || f_err_q.size() != 0 || f_frame !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_quiet: got rdy %0d err %0d frame %h want 0 0 00",
               f_dat_q.size(), f_err_q.size(), f_frame);
    end
    send(1'b0, 8'hFF, 1'b1, e0);
    hold(1'b0, 1'b1, 2 * NF);
    checks++;
    if (f_dat_q.size() != 1 || f_frame !== 8'hFF) begin
      errors++;
      $display("FAIL rst_mid_next: got rdy %0d frame %h want 1 ff", f_dat_q.size(), f_frame);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    logic [7:0] b;
    int exp_err, gap, e0;
    bit bad;
    clear_f();
    exp_err   = 0;
    last_good = 8'hFF;
    for (int n = 0; n < 10; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send(1'b0, b, !bad, e0);
      if (bad) begin
        exp_err++;
        gap = $urandom_range(1, NF);
      end else begin
        exp_q.push_back(b);
        last_good = b;
        gap = $urandom_range(0, NF);
      end
      if (gap > 0) hold(1'b0, 1'b1, gap);
    end
    hold(1'b0, 1'b1, 2 * NF);
    checks++;
    if (f_dat_q.size() != exp_q.size() || f_err_q.size() != exp_err) begin
      errors++;
      $display("FAIL rand_count: got rdy %0d err %0d want %0d %0d",
               f_dat_q.size(), f_err_q.size(), exp_q.size(), exp_err);
    end
    for (int i = 0; i < exp_q.size() && i < f_dat_q.size(); i++) begin
      checks++;
      if (f_dat_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %h want %h", i, f_dat_q[i], exp_q[i]);
      end
    end
    checks++;
    if (f_frame !== last_good) begin
      errors++;
      $display("FAIL rand_hold: got %h want %h", f_frame, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_default_latency();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_break();
    test_reset_midframe();
    test_random();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits directly upstream of the 16-bit sample assembler. Each valid byte is delivered as an 8-bit frame with a one-cycle ready pulse, which the assembler pairs into samples (MSB byte first). Bit timing comes from a fixed clocks-per-bit divider with mid-bit sampling.

## Interface
- CLKS_PER_BIT, 868, system clocks per bit period (100 MHz / 115200 baud); must be even and ≥ 4
- in_clk  input  1  system clock; all logic on the rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_rx  input  1  asynchronous serial line; idle high
- out_frame  output  8  last correctly received byte; held until the next valid frame
- out_ready  output  1  one-cycle pulse, high in the cycle after a valid stop bit is sampled
- out_frame_error  output  1  one-cycle pulse when a sampled stop bit is 0

## Operation
- in_rx passes through a 2-flop synchroniser, giving rx_s. Both flops reset to 1.
- States: IDLE, START, DATA, STOP, RECOVER.
- IDLE: when rx_s == 0, go to START with cnt = 0.
- START: cnt increments each cycle. At cnt == CLKS_PER_BIT/2 − 1, sample rx_s on the next edge:
  - rx_s == 0 → DATA, cnt = 0, bit_idx = 0.
  - rx_s == 1 → IDLE (glitch rejected; no output activity).
- DATA: at cnt == CLKS_PER_BIT − 1, shift rx_s into shift_reg[bit_idx] (LSB first), reset cnt to 0, increment bit_idx. After bit_idx 7 is sampled, go to STOP.
- STOP: at cnt == CLKS_PER_BIT − 1, sample rx_s:
  - rx_s == 1 → out_frame <= shift_reg, out_ready <= 1, go to IDLE.
  - rx_s == 0 → out_frame_error <= 1, out_frame unchanged, go to RECOVER.
- RECOVER: wait until rx_s == 1, then go to IDLE. Covers break conditions: exactly one error pulse per break, never a spurious start.
- out_ready and out_frame_error are never high together. Both are cleared every cycle in which they are not being set.
- Counter width is clog2(CLKS_PER_BIT). bit_idx is 3 bits. The counter never wraps uncontrolled; it is reset explicitly at each sample.
- in_rst at any time: state IDLE, cnt 0, bit_idx 0, shift_reg 0, sync flops 1. Any partial frame is discarded with no pulse. After release, a frame whose start bit began before release is not received unless the line shows a fresh falling edge.

## Timing
- Reset values: out_frame = 8'h00, out_ready = 0, out_frame_error = 0.
- Latency: let E0 be the first rising edge at which the synchroniser's first flop captures in_rx low. out_ready (or out_frame_error) is high in the cycle following edge E0 + 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. With the default, that is edge E0 + 8248.
- Data bit k (k = 0..7) is sampled at edge E0 + 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- The stop bit is sampled at its mid-point, and the FSM returns to IDLE immediately. A start bit following with zero idle time is detected correctly, so back-to-back frames are supported.
- out_frame changes on the same edge that raises out_ready and is stable for at least 10·CLKS_PER_BIT cycles afterwards.
- No back-pressure: the consumer must accept each out_ready pulse. Bytes are never buffered or dropped internally.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, RECOVER)
  - the default CLKS_PER_BIT constant
  - frame constants: DATA_BITS = 8, STOP_BITS = 1
- Sub-module sync2: generic 2-flop synchroniser with a reset-value parameter, instantiated with reset value 1.
- The FSM, counter and shift register live in uart_rx. Expected size is about 150 lines.

## Test plan
- Reset, then drive byte 0xA5 at CLKS_PER_BIT = 868 → exactly one out_ready pulse at the computed latency, out_frame = 8'hA5, no error pulse.
- Drive 0x12 then 0x34 back-to-back with no idle between stop and start → two out_ready pulses 8680 cycles apart, with out_frame = 8'h12 then 8'h34.
- Drive a low glitch of CLKS_PER_BIT/4 cycles on an idle line → no out_ready, no out_frame_error, FSM back in IDLE.
- Receive 0x3C, then send 0x55 with stop bit = 0 → one out_frame_error pulse, no out_ready, out_frame still 8'h3C.
- Hold in_rx low for 20 bit periods, then release and send 0x81 → exactly one error pulse, then out_ready with out_frame = 8'h81.
- Assert in_rst during data bit 4 of a frame, then release → no pulse, all outputs at reset values. The next full frame 0xFF is received correctly.
